phy_link_monitor: RTL and testbench

- Consumes the 16-bit words produced by mdioControl (from_MDI) together with its ready strobe.
- Treats each word as the PHY Basic Mode Status Register (reg 1) and debounces the link bit.
- Publishes link_up, autoneg-done and remote-fault flags plus a held link-change event for the downstream Ethernet MAC/controller logic.
- A watchdog flags stale data when mdioControl stops delivering words.

---
 rtl/phy_link_monitor.sv | 73 +++++++
 tb/tb_phy_link_monitor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/phy_link_monitor.sv
// phy_link_monitor: debounces the BMSR link bit from mdioControl words and flags status, link changes and stale data
module phy_link_monitor #(
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT = 2000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] from_MDI,
  input  logic        ready,
  input  logic        evt_ack,
  output logic        link_up,
  output logic        an_done,
  output logic        rem_fault,
  output logic        link_evt,
  output logic        stale,
  output logic [15:0] last_word,
  output logic [7:0]  sample_cnt
);
  typedef enum logic [1:0] {WAIT_FIRST, TRACK, STALE} state_t;
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  localparam logic [23:0] WD_MAX = 24'(TIMEOUT - 1);
  state_t state;
  logic ready_q, cand, accept, b, chg, timeout;
  logic [3:0] cnt, cnt_nxt;
  logic [23:0] wd;
  assign accept = ready & ~ready_q;
  assign b = from_MDI[2];
  assign cnt_nxt = (b == cand) ? ((cnt == DB) ? DB : cnt + 4'd1) : 4'd1;
  assign chg = accept && cnt_nxt == DB && b != link_up;
  // an accepted word always beats an expiring watchdog
  assign timeout = state == TRACK && !accept && wd == WD_MAX;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= WAIT_FIRST;
      ready_q <= 1'b0;
      cand <= 1'b0;
      cnt <= 4'd0;
      wd <= 24'd0;
      link_up <= 1'b0;
      an_done <= 1'b0;
      rem_fault <= 1'b0;
      link_evt <= 1'b0;
      stale <= 1'b0;
      last_word <= 16'd0;
      sample_cnt <= 8'd0;
    end else begin
      ready_q <= ready;
      link_evt <= (chg || (timeout && link_up)) ? 1'b1 : evt_ack ? 1'b0 : link_evt;
      if (accept) begin
        state <= TRACK;
        stale <= 1'b0;
        wd <= 24'd0;
        last_word <= from_MDI;
        an_done <= from_MDI[5];
        rem_fault <= from_MDI[4];
        sample_cnt <= sample_cnt + 8'd1;
        cand <= b;
        cnt <= cnt_nxt;
        link_up <= chg ? b : link_up;
      end else if (timeout) begin
        state <= STALE;
        stale <= 1'b1;
        wd <= 24'd0;
        link_up <= 1'b0;
        an_done <= 1'b0;
        rem_fault <= 1'b0;
        cnt <= 4'd0;
      end else if (state == TRACK) begin
        wd <= wd + 24'd1;
      end
    end
  end
endmodule

// File: tb/tb_phy_link_monitor.sv
// tb_phy_link_monitor: directed vector table plus hand-written multi-cycle sequences for phy_link_monitor
module tb_phy_link_monitor;
  logic CLK = 1'b0, RST_N = 1'b0, ready = 1'b0, evt_ack = 1'b0;
  logic [15:0] from_MDI = 16'd0;
  logic link_up, an_done, rem_fault, link_evt, stale;
  logic [15:0] last_word;
  logic [7:0] sample_cnt;
  logic u1_link, u1_an, u1_rf, u1_evt, u1_stale;
  logic [15:0] u1_lw;
  logic [7:0] u1_cnt;
  int errors = 0, checks = 0, n = 0;

  always #5 CLK = ~CLK;

  phy_link_monitor #(.DEBOUNCE(3), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST_N(RST_N), .from_MDI(from_MDI), .ready(ready), .evt_ack(evt_ack),
    .link_up(link_up), .an_done(an_done), .rem_fault(rem_fault), .link_evt(link_evt),
    .stale(stale), .last_word(last_word), .sample_cnt(sample_cnt)
  );

  phy_link_monitor #(.DEBOUNCE(1)) u1 (
    .CLK(CLK), .RST_N(RST_N), .from_MDI(from_MDI), .ready(ready), .evt_ack(evt_ack),
    .link_up(u1_link), .an_done(u1_an), .rem_fault(u1_rf), .link_evt(u1_evt),
    .stale(u1_stale), .last_word(u1_lw), .sample_cnt(u1_cnt)
  );

  typedef struct {
    logic [15:0] w;
    logic ack;
    logic l, e, a, r;
  } vec_t;
  vec_t vt[13];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic word(input logic [15:0] w);
    from_MDI = w;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    n++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " link_up"}, 32'(link_up), 0);
    chk({tag, " an_done"}, 32'(an_done), 0);
    chk({tag, " rem_fault"}, 32'(rem_fault), 0);
    chk({tag, " link_evt"}, 32'(link_evt), 0);
    chk({tag, " stale"}, 32'(stale), 0);
    chk({tag, " last_word"}, 32'(last_word), 0);
    chk({tag, " sample_cnt"}, 32'(sample_cnt), 0);
  endtask

  initial begin
    vt[0]  = '{16'h0024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{16'h0024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{16'h0024, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{16'h0020, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{16'h0034, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[5]  = '{16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{16'h0020, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{16'h0004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{16'h0024, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    tick();
    tick();
    chk_all_zero("reset");
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vt[i].ack) begin
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
      end
      word(vt[i].w);
      chk($sformatf("v%0d link_up", i), 32'(link_up), 32'(vt[i].l));
      chk($sformatf("v%0d link_evt", i), 32'(link_evt), 32'(vt[i].e));
      chk($sformatf("v%0d an_done", i), 32'(an_done), 32'(vt[i].a));
      chk($sformatf("v%0d rem_fault", i), 32'(rem_fault), 32'(vt[i].r));
      chk($sformatf("v%0d last_word", i), 32'(last_word), 32'(vt[i].w));
      chk($sformatf("v%0d sample_cnt", i), 32'(sample_cnt), 32'(n));
      chk($sformatf("v%0d db1 link_up", i), 32'(u1_link), 32'(vt[i].w[2]));
    end

    from_MDI = 16'h0024;
    ready = 1'b1;
    repeat (50) tick();
    ready = 1'b0;
    tick();
    n++;
    chk("held ready sample_cnt", 32'(sample_cnt), 32'(n));
    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("ack clears evt", 32'(link_evt), 0);

    word(16'h0024);
    repeat (98) tick();
    chk("pre-timeout stale", 32'(stale), 0);
    chk("pre-timeout link_up", 32'(link_up), 1);
    tick();
    chk("timeout stale", 32'(stale), 1);
    chk("timeout link_up", 32'(link_up), 0);
    chk("timeout link_evt", 32'(link_evt), 1);
    chk("timeout an_done", 32'(an_done), 0);
    word(16'h0004);
    chk("stale exit stale", 32'(stale), 0);
    chk("stale exit link_up", 32'(link_up), 0);
    chk("stale exit last_word", 32'(last_word), 32'h0004);
    word(16'h0004);
    chk("restart word2 link_up", 32'(link_up), 0);
    word(16'h0004);
    chk("restart word3 link_up", 32'(link_up), 1);
    chk("restart sample_cnt", 32'(sample_cnt), 32'(n));

    evt_ack = 1'b1;
    tick();
    evt_ack = 1'b0;
    chk("ack before race", 32'(link_evt), 0);
    word(16'h0000);
    word(16'h0000);
    from_MDI = 16'h0000;
    ready = 1'b1;
    evt_ack = 1'b1;
    tick();
    n++;
    chk("race link_up", 32'(link_up), 0);
    chk("race set wins", 32'(link_evt), 1);
    ready = 1'b0;
    tick();
    evt_ack = 1'b0;
    chk("race late ack", 32'(link_evt), 0);

    word(16'h0000);
    repeat (98) tick();
    from_MDI = 16'h0001;
    ready = 1'b1;
    tick();
    n++;
    ready = 1'b0;
    chk("word vs timeout stale", 32'(stale), 0);
    chk("word vs timeout last_word", 32'(last_word), 32'h0001);
    tick();
    chk("word vs timeout after", 32'(stale), 0);
    chk("word vs timeout sample_cnt", 32'(sample_cnt), 32'(n));

    word(16'h0004);
    word(16'h0004);
    #2;
    RST_N = 1'b0;
    #1;
    chk_all_zero("async reset");
    #2;
    RST_N = 1'b1;
    tick();
    chk_all_zero("post reset");
    for (int i = 0; i < 300; i++) begin
      word(16'h0024);
      if (i == 1) chk("post reset debounce", 32'(link_up), 0);
    end
    chk("wrap sample_cnt", 32'(sample_cnt), 44);
    chk("wrap link_up", 32'(link_up), 1);
    chk("wrap last_word", 32'(last_word), 32'h0024);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
